// File: rtl/coffee_pkg.sv
// coffee_pkg: coffee type encoding, sequencer states and per-type recipe units
package coffee_pkg;
   typedef enum logic [1:0] {FILTER = 2'b00, BLACK = 2'b01, BRU = 2'b10, NESCAFE = 2'b11} coffee_t;
   typedef enum logic [2:0] {S_IDLE, S_CUP, S_POWDER, S_WATER, S_DONE, S_FAULT} state_t;
   function automatic int unsigned price_units(input coffee_t c);
      return c == FILTER ? 2 : c == BLACK ? 1 : c == BRU ? 5 : 10;
   endfunction
   function automatic int unsigned powder_units(input coffee_t c);
      return c == FILTER ? 1 : c == BLACK ? 0 : 2;
   endfunction
endpackage

// File: rtl/coffee_dispense_seq_if.sv
// coffee_dispense_seq_if: order inputs and actuator/status outputs of the dispense sequencer
interface coffee_dispense_seq_if;
   import coffee_pkg::*;
   logic dispense_req;
   coffee_t coffee_sel;
   logic cup_present;
   logic fault_clr;
   logic cup_drop, powder_valve, water_valve, led_yellow, led_green, fault, busy, pending, done;
   logic [7:0] drop_cnt;
   modport master (
      output dispense_req, coffee_sel, cup_present, fault_clr,
      input cup_drop, powder_valve, water_valve, led_yellow, led_green, fault, busy, pending, done, drop_cnt
   );
   modport slave (
      input dispense_req, coffee_sel, cup_present, fault_clr,
      output cup_drop, powder_valve, water_valve, led_yellow, led_green, fault, busy, pending, done, drop_cnt
   );
endinterface

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that parks at zero and flags it
module phase_timer #(
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] value,
   output logic          zero
);
   logic [TW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= load ? value : cnt - TW'(cnt != '0);
   assign zero = cnt == '0;
endmodule

// File: rtl/coffee_dispense_seq.sv
// coffee_dispense_seq: runs cup, powder, water and done phases per order with a one-deep order queue
module coffee_dispense_seq
   import coffee_pkg::*;
#(
   parameter int CUP_CYCLES  = 4,
   parameter int POWDER_UNIT = 3,
   parameter int WATER_UNIT  = 8,
   parameter int DONE_CYCLES = 6,
   parameter int TW          = 16
) (
   input logic clk,
   input logic rst,
   coffee_dispense_seq_if.slave bus
);
   localparam longint LIM = longint'(1) << TW;
   if (CUP_CYCLES < 1 || DONE_CYCLES < 1 || POWDER_UNIT < 1 || WATER_UNIT < 1 ||
       longint'(CUP_CYCLES) > LIM || longint'(DONE_CYCLES) > LIM ||
       2 * longint'(POWDER_UNIT) > LIM || 10 * longint'(WATER_UNIT) > LIM) begin : g_bad_params
      $error("coffee_dispense_seq: every phase length must be >= 1 and fit in TW bits");
   end
   state_t state, nxt;
   coffee_t act_sel, pend_sel;
   logic zero, load, active, take, bypass, store, drop;
   logic [TW-1:0] load_val;
   always_comb begin
      nxt = state;
      take = 1'b0;
      bypass = 1'b0;
      case (state)
         S_IDLE:   nxt = bus.dispense_req ? S_CUP : S_IDLE;
         S_CUP:    if (zero) nxt = !bus.cup_present ? S_FAULT : powder_units(act_sel) == 0 ? S_WATER : S_POWDER;
         S_POWDER: nxt = zero ? S_WATER : S_POWDER;
         S_WATER:  nxt = zero ? S_DONE : S_WATER;
         S_DONE:   if (zero) begin
            take = bus.pending;
            bypass = !bus.pending && bus.dispense_req;
            nxt = take || bypass ? S_CUP : S_IDLE;
         end
         S_FAULT:  nxt = bus.fault_clr ? S_IDLE : S_FAULT;
         default:  nxt = S_IDLE;
      endcase
   end
   assign active = state inside {S_CUP, S_POWDER, S_WATER, S_DONE};
   // consuming the queued order frees its slot for a request in the same cycle
   assign store = bus.dispense_req && active && !bypass && (!bus.pending || take) && nxt != S_FAULT;
   assign drop = bus.dispense_req && (state == S_FAULT || (active && bus.pending && !take));
   assign load = nxt != state;
   assign load_val = nxt == S_CUP    ? TW'(CUP_CYCLES - 1) :
                     nxt == S_POWDER ? TW'(powder_units(act_sel) * POWDER_UNIT - 1) :
                     nxt == S_WATER  ? TW'(price_units(act_sel) * WATER_UNIT - 1) :
                                       TW'(DONE_CYCLES - 1);
   phase_timer #(.TW(TW)) timer (.clk(clk), .rst(rst), .load(load), .value(load_val), .zero(zero));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S_IDLE;
         act_sel <= FILTER;
         pend_sel <= FILTER;
         bus.pending <= 1'b0;
         bus.drop_cnt <= 8'd0;
         bus.cup_drop <= 1'b0;
         bus.powder_valve <= 1'b0;
         bus.water_valve <= 1'b0;
         bus.led_yellow <= 1'b0;
         bus.led_green <= 1'b0;
         bus.fault <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state <= nxt;
         act_sel <= take ? pend_sel : (nxt == S_CUP && state != S_CUP) ? bus.coffee_sel : act_sel;
         pend_sel <= store ? bus.coffee_sel : pend_sel;
         bus.pending <= nxt == S_FAULT ? 1'b0 : store ? 1'b1 : take ? 1'b0 : bus.pending;
         bus.drop_cnt <= bus.drop_cnt + 8'(drop && bus.drop_cnt != 8'hff);
         bus.cup_drop <= nxt == S_CUP;
         bus.powder_valve <= nxt == S_POWDER;
         bus.water_valve <= nxt == S_WATER;
         bus.led_yellow <= nxt inside {S_CUP, S_POWDER, S_WATER};
         bus.led_green <= nxt == S_DONE;
         bus.fault <= nxt == S_FAULT;
         bus.busy <= nxt != S_IDLE;
         bus.done <= nxt == S_DONE && state != S_DONE;
      end
endmodule
